muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the Mul/Div ALU operations; owns the architectural HI/LO registers.
- Started by main control when ALUOp decodes to Mul or Div.
- Runs a shift-add multiply or restoring divide over WIDTH iterations.
- Stalls the pipeline via Stall until HI/LO hold the result; Mfhi/Mflo read Hi/Lo directly.

---
 rtl/muldiv_sequencer_pkg.sv | 15 +
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_sequencer.sv | 154 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer:
// the OpDiv operation select and the 2-bit FSM state codes.
package muldiv_sequencer_pkg;

  localparam logic MulDiv_Mul = 1'b0;
  localparam logic MulDiv_Div = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step
// on unsigned magnitudes. The caller shifts q_bit_o into its working register.
module muldiv_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op_i,
  input  logic [WIDTH:0]   acc_i,
  input  logic             q_lsb_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH:0]   acc_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = acc_i + (q_lsb_i ? {1'b0, opnd_i} : '0);
    shifted = {acc_i[WIDTH-1:0], q_msb_i};
    diff    = shifted - {1'b0, opnd_i};
    if (op_i == MulDiv_Div) begin
      // A borrow out of the trial subtraction means the divisor did not fit
      q_bit_o = ~diff[WIDTH];
      acc_o   = diff[WIDTH] ? shifted : diff;
    end else begin
      q_bit_o = sum[0];
      acc_o   = {1'b0, sum[WIDTH:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MUL/DIV sequencer owning the HI/LO registers; stalls the
// pipeline from Start acceptance until the result is written.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             OpDiv,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   step_opnd;
  logic [WIDTH:0]     step_acc;
  logic               step_bit;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic               neg;

  // Most-negative input maps to 2^(WIDTH-1), which still fits unsigned
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign step_opnd = (op_q == MulDiv_Div) ? mag_b_q : mag_a_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_i    (op_q),
    .acc_i   (acc_q),
    .q_lsb_i (q_q[0]),
    .q_msb_i (q_q[WIDTH-1]),
    .opnd_i  (step_opnd),
    .acc_o   (step_acc),
    .q_bit_o (step_bit)
  );

  assign neg    = sign_a_q ^ sign_b_q;
  assign prod   = {acc_q[WIDTH-1:0], q_q};
  assign prod_s = neg ? -prod : prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    q_d      = q_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d  = S_LOAD;
          op_d     = OpDiv;
          sign_a_d = A[WIDTH-1];
          sign_b_d = B[WIDTH-1];
          mag_a_d  = abs_val(A);
          mag_b_d  = abs_val(B);
        end
      end
      S_LOAD: begin
        acc_d   = '0;
        q_d     = (op_q == MulDiv_Div) ? mag_a_q : mag_b_q;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        acc_d = step_acc;
        // Divide builds the quotient from the LSB end; multiply retires product bits from the top
        q_d   = (op_q == MulDiv_Div) ? {q_q[WIDTH-2:0], step_bit}
                                     : {step_bit, q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (op_q == MulDiv_Mul) begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end else if (mag_b_q == '0) begin
          hi_d = sign_a_q ? -mag_a_q : mag_a_q;
          lo_d = '1;
        end else begin
          hi_d = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          lo_d = neg ? -q_q : q_q;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign Busy  = (state_q != S_IDLE);
  assign Stall = Busy | (Start & (state_q == S_IDLE));
  assign Done  = done_q;
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected {Hi,Lo} pushed at Start,
// popped and compared when Done pulses; cycle n is the period after edge n-1.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Start = 1'b0;
  logic         OpDiv = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy, Stall, Done;
  logic [W-1:0] Hi, Lo;

  int n_pass  = 0;
  int n_total = 0;
  logic [2*W-1:0] sb_q[$];

  always #5 Clk = ~Clk;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .OpDiv(OpDiv), .A(A), .B(B),
    .Busy(Busy), .Stall(Stall), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  // Reference result {Hi,Lo} from native signed arithmetic
  function automatic logic [2*W-1:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    logic signed [W-1:0]   q, r;
    if (!op) begin
      p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      return p;
    end
    if (b == '0) return {a, {W{1'b1}}};
    if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return {{W{1'b0}}, a};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  task automatic drive_start(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input logic push);
    Start = 1'b1; OpDiv = op; A = a; B = b;
    if (push) sb_q.push_back(model(op, a, b));
  endtask

  task automatic test_reset();
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    n_total++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else n_pass++;
    n_total++; if (Stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", Stall); else n_pass++;
    n_total++; if (Done !== 1'b0) $display("FAIL reset_done: got %b want 0", Done); else n_pass++;
    n_total++; if (Hi !== '0) $display("FAIL reset_hi: got %h want 0", Hi); else n_pass++;
    n_total++; if (Lo !== '0) $display("FAIL reset_lo: got %h want 0", Lo); else n_pass++;
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_ops();
    logic         to[10];
    logic [W-1:0] ta[10], tb_[10];
    logic [2*W-1:0] prev, got, exp;
    int busy_err, hold_err, n_done, done_cyc;
    logic exp_busy;
    to[0] = 0; ta[0] = 32'd7;        tb_[0] = 32'hFFFF_FFFD;
    to[1] = 1; ta[1] = 32'hFFFF_FFF9; tb_[1] = 32'd2;
    to[2] = 0; ta[2] = 32'h8000_0000; tb_[2] = 32'h8000_0000;
    to[3] = 1; ta[3] = 32'd100;      tb_[3] = 32'd0;
    to[4] = 1; ta[4] = 32'h8000_0000; tb_[4] = 32'hFFFF_FFFF;
    to[5] = 1; ta[5] = 32'd7;        tb_[5] = 32'hFFFF_FFFE;
    for (int i = 6; i < 10; i++) begin
      to[i] = 1'($urandom_range(0, 1)); ta[i] = $urandom; tb_[i] = $urandom;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      prev = {Hi, Lo};
      drive_start(to[i], ta[i], tb_[i], 1'b1);
      #1;
      n_total++; if (Stall !== 1'b1) $display("FAIL op%0d_stall_on_start: got %b want 1", i, Stall); else n_pass++;
      @(posedge Clk);
      busy_err = 0; hold_err = 0; n_done = 0; done_cyc = -1; got = '0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge Clk);
        exp_busy = (n <= 34);
        if (Busy !== exp_busy || Stall !== exp_busy) busy_err++;
        if (Done === 1'b1) begin n_done++; done_cyc = n; got = {Hi, Lo}; end
        else if (n < 35 && {Hi, Lo} !== prev) hold_err++;
        else if (n > 35 && {Hi, Lo} !== got) hold_err++;
        if (n == 1) Start = 1'b0;
      end
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : ~got;
      n_total++; if (got !== exp) $display("FAIL op%0d_result: got %h want %h", i, got, exp); else n_pass++;
      n_total++; if (done_cyc != 35) $display("FAIL op%0d_done_cycle: got %0d want 35", i, done_cyc); else n_pass++;
      n_total++; if (n_done != 1) $display("FAIL op%0d_done_count: got %0d want 1", i, n_done); else n_pass++;
      n_total++; if (busy_err != 0) $display("FAIL op%0d_busy_stall: got %0d bad cycles want 0", i, busy_err); else n_pass++;
      n_total++; if (hold_err != 0) $display("FAIL op%0d_hilo_hold: got %0d bad cycles want 0", i, hold_err); else n_pass++;
    end
  endtask

  task automatic test_restart_ignored();
    logic [2*W-1:0] got, exp;
    int n_done, done_cyc, busy_err;
    @(negedge Clk);
    drive_start(1'b0, 32'd5, 32'd6, 1'b1);
    @(posedge Clk);
    n_done = 0; done_cyc = -1; busy_err = 0; got = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      if (Busy !== (n <= 34) || Stall !== (n <= 34 || (n == 10))) busy_err++;
      if (Done === 1'b1) begin n_done++; done_cyc = n; got = {Hi, Lo}; end
      if (n == 1) Start = 1'b0;
      if (n == 9) drive_start(1'b1, 32'd1, 32'd1, 1'b0);
      if (n == 10) Start = 1'b0;
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : ~got;
    n_total++; if (got !== exp) $display("FAIL restart_result: got %h want %h", got, exp); else n_pass++;
    n_total++; if (n_done != 1 || done_cyc != 35) $display("FAIL restart_done: got %0d pulses last at %0d want 1 at 35", n_done, done_cyc); else n_pass++;
    n_total++; if (busy_err != 0) $display("FAIL restart_busy: got %0d bad cycles want 0", busy_err); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [2*W-1:0] got, exp;
    int n_done, done_cyc;
    @(negedge Clk);
    drive_start(1'b1, 32'hFFFF_FC18, 32'd7, 1'b1);
    @(posedge Clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (n == 1) Start = 1'b0;
    end
    #2 Reset_n = 1'b0;
    #1;
    n_total++; if (Busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", Busy); else n_pass++;
    n_total++; if ({Hi, Lo} !== '0) $display("FAIL areset_hilo: got %h want 0", {Hi, Lo}); else n_pass++;
    n_total++; if (Done !== 1'b0) $display("FAIL areset_done: got %b want 0", Done); else n_pass++;
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    n_done = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clk);
      if (Done === 1'b1 || Busy !== 1'b0) n_done++;
    end
    n_total++; if (n_done != 0) $display("FAIL areset_no_done: got %0d active cycles want 0", n_done); else n_pass++;
    drive_start(1'b0, 32'hFFFF_FFF7, 32'd11, 1'b1);
    @(posedge Clk);
    n_done = 0; done_cyc = -1; got = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin n_done++; done_cyc = n; got = {Hi, Lo}; end
      if (n == 1) Start = 1'b0;
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : ~got;
    n_total++; if (got !== exp) $display("FAIL areset_after_result: got %h want %h", got, exp); else n_pass++;
    n_total++; if (n_done != 1 || done_cyc != 35) $display("FAIL areset_after_done: got %0d pulses last at %0d want 1 at 35", n_done, done_cyc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] got[2], exp;
    int done_at[2];
    int n_done, busy_err;
    logic eb;
    @(negedge Clk);
    drive_start(1'b1, 32'd1000, 32'hFFFF_FFFD, 1'b1);
    @(posedge Clk);
    n_done = 0; busy_err = 0;
    done_at[0] = -1; done_at[1] = -1; got[0] = '0; got[1] = '0;
    for (int n = 1; n <= 75; n++) begin
      @(negedge Clk);
      if (n == 35) drive_start(1'b0, 32'hFFFF_CFC7, 32'd678, 1'b1);
      if (n == 36) Start = 1'b0;
      #1;
      eb = (n <= 34) || (n >= 36 && n <= 69);
      if (Busy !== eb || Stall !== (eb || n == 35)) busy_err++;
      if (Done === 1'b1) begin
        if (n_done < 2) begin got[n_done] = {Hi, Lo}; done_at[n_done] = n; end
        n_done++;
      end
      if (n == 1) Start = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : ~got[k];
      n_total++; if (got[k] !== exp) $display("FAIL b2b_result%0d: got %h want %h", k, got[k], exp); else n_pass++;
    end
    n_total++; if (done_at[0] != 35 || done_at[1] != 70 || n_done != 2)
      $display("FAIL b2b_done: got %0d pulses at %0d,%0d want 2 at 35,70", n_done, done_at[0], done_at[1]); else n_pass++;
    n_total++; if (busy_err != 0) $display("FAIL b2b_busy_stall: got %0d bad cycles want 0", busy_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_restart_ignored();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
